// File: rtl/uart_sender_if.sv
// rtl/uart_sender_if.sv - byte handshake between UART controller and uart_sender
interface uart_sender_if;
   logic [7:0] TX_DATA;
   logic       TX_EN;
   logic       TX_STATUS;

   modport master (output TX_DATA, output TX_EN, input TX_STATUS);
   modport slave  (input TX_DATA, input TX_EN, output TX_STATUS);
endinterface

// File: rtl/uart_sender.sv
// rtl/uart_sender.sv - 8-N-1 UART transmitter; define UART_PARITY_EN for 8-E-1 framing
module uart_sender #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic         clk,
   input  logic         reset,
   uart_sender_if.slave tx_if,
   output logic         UART_TX
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          status_q, status_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         status_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         status_q <= status_d;
      end
   end

   // Outputs are computed one edge ahead so UART_TX and TX_STATUS stay registered.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      status_d = status_q;
      case (state_q)
         IDLE: begin
            tx_d     = 1'b1;
            status_d = 1'b1;
            if (tx_if.TX_EN) begin
               shift_d  = tx_if.TX_DATA;
               state_d  = START;
               cnt_d    = '0;
               idx_d    = '0;
               tx_d     = 1'b0;
               status_d = 1'b0;
            end
         end
         START: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^shift_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = STOP;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d    = '0;
               state_d  = IDLE;
               tx_d     = 1'b1;
               status_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            tx_d     = 1'b1;
            status_d = 1'b1;
         end
      endcase
   end

   assign UART_TX         = tx_q;
   assign tx_if.TX_STATUS = status_q;

endmodule

// File: tb/tb_uart_sender.sv
// tb/tb_uart_sender.sv - directed self-checking bench for uart_sender at CLKS_PER_BIT=4
module tb_uart_sender;

   localparam int CPB = 4;

   logic clk;
   logic reset;
   logic uart_tx;
   int   tests;
   int   fails;

   uart_sender_if u_if ();

   uart_sender #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_if   (u_if.slave),
      .UART_TX (uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // exp holds the frame in time order, first bit in exp[nbits-1]; call right after the accepting edge.
   // inject >= 0 pulses TX_EN with TX_DATA=0xFF at that cycle of the frame.
   task automatic check_frame(input string tag, input logic [10:0] exp, input int nbits,
                              input int inject);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < CPB; c++) begin
            chk({tag, "_tx"}, uart_tx, exp[nbits - 1 - b]);
            chk({tag, "_busy"}, u_if.TX_STATUS, 1'b0);
            if (inject == b * CPB + c) begin
               u_if.TX_DATA = 8'hFF;
               u_if.TX_EN   = 1'b1;
            end
            tick();
            if (inject >= 0) u_if.TX_EN = 1'b0;
         end
      end
      chk({tag, "_done_status"}, u_if.TX_STATUS, 1'b1);
      chk({tag, "_done_tx"}, uart_tx, 1'b1);
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         chk({tag, "_status"}, u_if.TX_STATUS, 1'b1);
         chk({tag, "_tx"}, uart_tx, 1'b1);
      end
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      u_if.TX_EN   = 1'b0;
      u_if.TX_DATA = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_status", u_if.TX_STATUS, 1'b1);
      chk("reset_tx", uart_tx, 1'b1);

      // 0x55 single pulse
      u_if.TX_DATA = 8'h55;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("f55", 11'b00101010101, 10, -1);
      check_idle("f55_idle", 3);

      // 0xA3 with an ignored mid-frame request carrying 0xFF
      u_if.TX_DATA = 8'hA3;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("fA3", 11'b00110001011, 10, 13);
      check_idle("fA3_noqueue", 45);

      // TX_EN held high: frames 41 cycles apart with one idle cycle
      u_if.TX_DATA = 8'h0F;
      u_if.TX_EN   = 1'b1;
      tick();
      check_frame("f0F_a", 11'b00111100001, 10, -1);
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("f0F_b", 11'b00111100001, 10, -1);
      check_idle("f0F_idle", 3);

      // reset during data bit 3 of 0x00
      u_if.TX_DATA = 8'h00;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      chk("f00_bit3_tx", uart_tx, 1'b0);
      chk("f00_bit3_busy", u_if.TX_STATUS, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset_status", u_if.TX_STATUS, 1'b1);
      chk("midreset_tx", uart_tx, 1'b1);
      check_idle("midreset_idle", 8);
      u_if.TX_DATA = 8'h81;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("f81", 11'b00100000011, 10, -1);

`ifdef UART_PARITY_EN
      tick();
      u_if.TX_DATA = 8'h07;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("p07", 11'b01110000011, 11, -1);
      tick();
      u_if.TX_DATA = 8'h03;
      u_if.TX_EN   = 1'b1;
      tick();
      u_if.TX_EN = 1'b0;
      check_frame("p03", 11'b01100000001, 11, -1);
`endif

      // reset and TX_EN on the same edge
      tick();
      u_if.TX_DATA = 8'h5A;
      u_if.TX_EN   = 1'b1;
      reset        = 1'b1;
      tick();
      reset      = 1'b0;
      u_if.TX_EN = 1'b0;
      chk("rst_en_status", u_if.TX_STATUS, 1'b1);
      chk("rst_en_tx", uart_tx, 1'b1);
      check_idle("rst_en_idle", 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
